// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the bit-period
// helper used by both the transmitter and the receiver so both ends agree on timing.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  function automatic int baud_width(input int clock_speed, input int baud_rate);
    return clock_speed / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side pin and byte-output bundle; master is the receiver, slave is the
// byte consumer (which also owns the serial line in a loopback or bench setup).
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx,
    output data,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input; two cycles of latency, no
// backpressure. The reset value should match the input's idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver with mid-bit sampling; byte strobed 4126 cycles after the start edge
// at defaults. No backpressure: a missed rx_valid pulse loses the byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE   = 115_200,
  parameter int CLOCK_SPEED = 50_000_000
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int BAUD_WIDTH = baud_width(CLOCK_SPEED, BAUD_RATE);
  localparam int HALF_WIDTH = BAUD_WIDTH / 2;
  localparam int CNT_W      = $clog2(BAUD_WIDTH);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_WIDTH - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_WIDTH - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t       state_q, state_d;
  logic [CNT_W-1:0]     clk_counter_q, clk_counter_d;
  logic [2:0]           bit_index_q, bit_index_d;
  logic [DATA_BITS-1:0] shift_reg_q, shift_reg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      clk_counter_q <= '0;
      bit_index_q   <= '0;
      shift_reg_q   <= '0;
      data_q        <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_counter_q <= clk_counter_d;
      bit_index_q   <= bit_index_d;
      shift_reg_q   <= shift_reg_d;
      data_q        <= data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // The counter restarts from zero on every state change so each phase times from its own entry.
  always_comb begin
    state_d       = state_q;
    clk_counter_d = clk_counter_q + CNT_W'(1);
    bit_index_d   = bit_index_q;
    shift_reg_d   = shift_reg_q;
    data_d        = data_q;
    rx_valid_d    = 1'b0;
    frame_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        clk_counter_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (clk_counter_q == HALF_LAST) begin
          clk_counter_d = '0;
          if (!rx_s) begin
            state_d     = DATA;
            bit_index_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (clk_counter_q == BAUD_LAST) begin
          clk_counter_d = '0;
          shift_reg_d   = {rx_s, shift_reg_q[DATA_BITS-1:1]};
          if (bit_index_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (clk_counter_q == BAUD_LAST) begin
          clk_counter_d = '0;
          if (rx_s) begin
            data_d     = shift_reg_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end

      BREAK: begin
        // A line stuck low must rise before another start bit can be recognised.
        clk_counter_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d       = IDLE;
        clk_counter_d = '0;
      end
    endcase
  end

  assign bus.data      = data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
